// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit: shift-add multiply, restoring divide,
// operands held as magnitudes with sign correction applied once at the end.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, SIGN, FIX} state_t;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    logic [WIDTH-1:0] m;
    m = v;
    if (is_signed && v[WIDTH-1]) m = ~m + WIDTH'(1);
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v, input logic do_neg);
    return do_neg ? (~v + WIDTH'(1)) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] negate_wide(input logic [2*WIDTH-1:0] v,
                                                     input logic do_neg);
    return do_neg ? (~v + (2*WIDTH)'(1)) : v;
  endfunction

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] p_hi_q, p_hi_d;
  logic [WIDTH-1:0] p_lo_q, p_lo_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             is_div_q, is_div_d;
  logic             is_signed_q, is_signed_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    p_hi_d        = p_hi_q;
    p_lo_d        = p_lo_q;
    mcand_d       = mcand_q;
    is_div_d      = is_div_q;
    is_signed_d   = is_signed_q;
    neg_lo_d      = neg_lo_q;
    neg_hi_d      = neg_hi_q;
    dz_d          = dz_q;
    hi_d          = hi_q;
    lo_d          = lo_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    div_by_zero_d = div_by_zero_q;
    sum           = '0;
    shifted       = '0;
    diff          = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d    = op[1];
          is_signed_d = ~op[0];
          neg_hi_d    = ~op[0] & a[WIDTH-1];
          neg_lo_d    = ~op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
          busy_d      = 1'b1;
          cnt_d       = '0;
          if (op[1] && (b == '0)) begin
            // Divide by zero bypasses the iterations; hi keeps the raw dividend.
            dz_d    = 1'b1;
            p_hi_d  = a;
            p_lo_d  = '1;
            state_d = SIGN;
          end else begin
            dz_d    = 1'b0;
            p_hi_d  = '0;
            state_d = RUN;
            if (op[1]) begin
              p_lo_d  = magnitude(a, ~op[0]);
              mcand_d = magnitude(b, ~op[0]);
            end else begin
              p_lo_d  = magnitude(b, ~op[0]);
              mcand_d = magnitude(a, ~op[0]);
            end
          end
        end
      end

      RUN: begin
        if (is_div_q) begin
          // Remainder stays below the divisor, so WIDTH+1 bits hold the trial shift.
          shifted = {p_hi_q, p_lo_q[WIDTH-1]};
          diff    = shifted - {1'b0, mcand_q};
          if (!diff[WIDTH]) begin
            p_hi_d = diff[WIDTH-1:0];
            p_lo_d = {p_lo_q[WIDTH-2:0], 1'b1};
          end else begin
            p_hi_d = shifted[WIDTH-1:0];
            p_lo_d = {p_lo_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          sum              = {1'b0, p_hi_q} + (p_lo_q[0] ? {1'b0, mcand_q} : '0);
          {p_hi_d, p_lo_d} = {sum, p_lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) state_d = SIGN;
      end

      SIGN: begin
        if (is_signed_q && !dz_q) begin
          if (is_div_q) begin
            p_lo_d = negate(p_lo_q, neg_lo_q);
            p_hi_d = negate(p_hi_q, neg_hi_q);
          end else begin
            {p_hi_d, p_lo_d} = negate_wide({p_hi_q, p_lo_q}, neg_lo_q);
          end
        end
        state_d = FIX;
      end

      FIX: begin
        hi_d          = p_hi_q;
        lo_d          = p_lo_q;
        done_d        = 1'b1;
        busy_d        = 1'b0;
        div_by_zero_d = dz_q;
        cnt_d         = '0;
        state_d       = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      p_hi_q        <= '0;
      p_lo_q        <= '0;
      mcand_q       <= '0;
      is_div_q      <= 1'b0;
      is_signed_q   <= 1'b0;
      neg_lo_q      <= 1'b0;
      neg_hi_q      <= 1'b0;
      dz_q          <= 1'b0;
      hi_q          <= '0;
      lo_q          <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      p_hi_q        <= p_hi_d;
      p_lo_q        <= p_lo_d;
      mcand_q       <= mcand_d;
      is_div_q      <= is_div_d;
      is_signed_q   <= is_signed_d;
      neg_lo_q      <= neg_lo_d;
      neg_hi_q      <= neg_hi_d;
      dz_q          <= dz_d;
      hi_q          <= hi_d;
      lo_q          <= lo_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: cycle-level arithmetic model for WIDTH=32 plus
// directed vectors with literal expectations, and a WIDTH=8 instance.
module tb_mul_div_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dz8;
  logic [7:0]  hi8, lo8;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clock(clk), .reset(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(dz)
  );

  mul_div_unit #(.WIDTH(8)) dut8 (
    .clock(clk), .reset(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .hi(hi8), .lo(lo8), .div_by_zero(dz8)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } res_t;

  // Reference arithmetic straight from the MIPS definitions.
  function automatic res_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    res_t        r;
    longint      sx, sy, q, m;
    logic [63:0] p;
    sx   = $signed(x);
    sy   = $signed(y);
    r    = '0;
    case (o)
      2'b00: begin p = 64'(sx * sy); r.hi = p[63:32]; r.lo = p[31:0]; end
      2'b01: begin p = {32'b0, x} * {32'b0, y}; r.hi = p[63:32]; r.lo = p[31:0]; end
      default: begin
        if (y == 32'd0) begin
          r.hi = x; r.lo = '1; r.dz = 1'b1;
        end else if (o == 2'b10) begin
          q = sx / sy; m = sx % sy;
          r.lo = q[31:0]; r.hi = m[31:0];
        end else begin
          r.lo = x / y; r.hi = x % y;
        end
      end
    endcase
    return r;
  endfunction

  logic        m_busy, m_done, m_dz;
  logic [31:0] m_hi, m_lo;
  int          left;
  res_t        pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_hi <= 0; m_lo <= 0; m_dz <= 0; left <= 0;
    end else if (left != 0) begin
      left <= left - 1;
      if (left == 1) begin
        m_busy <= 0; m_done <= 1; m_hi <= pend.hi; m_lo <= pend.lo; m_dz <= pend.dz;
      end
    end else begin
      m_done <= 0;
      if (start) begin
        pend   <= model(op, a, b);
        left   <= (op[1] && b == 32'd0) ? 2 : 34;
        m_busy <= 1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_busy", busy, m_busy);
      chk("cyc_done", done, m_done);
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
      chk("cyc_dz", dz, m_dz);
    end
  end

  task automatic start_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done(output int n, output bit busy_dropped);
    n = 0;
    busy_dropped = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!done && !busy) busy_dropped = 1;
    end while (!done && n < 200);
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] eh, input logic [31:0] el,
                        input logic edz, input int lat);
    int n;
    bit dropped;
    start_op(o, x, y);
    wait_done(n, dropped);
    chk({name, "_latency"}, n, lat);
    chk({name, "_busy_hold"}, dropped, 0);
    chk({name, "_busy_low"}, busy, 0);
    chk({name, "_hi"}, hi, eh);
    chk({name, "_lo"}, lo, el);
    chk({name, "_dz"}, dz, edz);
  endtask

  task automatic run8(input string name, input logic [1:0] o, input logic [7:0] x,
                      input logic [7:0] y, input logic [7:0] eh, input logic [7:0] el);
    int n;
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; start8 = 1;
    @(posedge clk);
    @(negedge clk);
    start8 = 0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!done8 && n < 100);
    chk({name, "_latency"}, n, 10);
    chk({name, "_hi"}, hi8, eh);
    chk({name, "_lo"}, lo8, el);
  endtask

  initial begin
    int  n;
    bit  dropped;
    bit  saw_done;
    clk = 0; rst_n = 0; start = 0; op = 0; a = 0; b = 0;
    start8 = 0; op8 = 0; a8 = 0; b8 = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    chk("rst_dz", dz, 0);
    chk("rst_busy8", busy8, 0);
    rst_n  = 1;
    cmp_en = 1;

    run_op("mult_m3x5", 2'b00, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 34);
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 34);
    run_op("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 34);
    run_op("div_7dm2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 34);
    run_op("mult_m1xm1", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1, 0, 34);
    run_op("divu_zero", 2'b11, 32'h100, 32'd0, 32'h100, 32'hFFFFFFFF, 1, 2);
    run_op("mult_2x3", 2'b00, 32'd2, 32'd3, 32'h0, 32'h6, 0, 34);
    run_op("div_zero", 2'b10, 32'hFFFFFF00, 32'd0, 32'hFFFFFF00, 32'hFFFFFFFF, 1, 2);
    run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 0, 34);
    run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0, 34);
    run_op("divu_big", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 0, 34);

    // Second start while busy is ignored; start during done is accepted.
    start_op(2'b00, 32'd12345, 32'hFFFFFFF6);
    repeat (4) @(posedge clk);
    @(negedge clk);
    op = 2'b01; a = 32'd3; b = 32'd4; start = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    wait_done(n, dropped);
    chk("ignore_latency", n + 5, 34);
    chk("ignore_hi", hi, 32'hFFFFFFFF);
    chk("ignore_lo", lo, 32'hFFFE1DC6);
    chk("b2b_done_high", done, 1);
    run_op("b2b_second", 2'b01, 32'h0000FFFF, 32'h00010001, 32'h0, 32'hFFFFFFFF, 0, 34);

    // Reset in the middle of an operation.
    start_op(2'b01, 32'd7, 32'd9);
    repeat (10) @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_hi", hi, 0);
    chk("midrst_lo", lo, 0);
    chk("midrst_dz", dz, 0);
    saw_done = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) saw_done = 1;
    end
    @(negedge clk);
    rst_n = 1;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) saw_done = 1;
    end
    chk("midrst_no_done", saw_done, 0);
    run_op("after_rst", 2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 0, 34);

    run8("w8_multu", 2'b01, 8'hFF, 8'hFF, 8'hFE, 8'h01);
    run8("w8_div_ovf", 2'b10, 8'h80, 8'hFF, 8'h00, 8'h80);
    run8("w8_mult_neg", 2'b00, 8'hFD, 8'h05, 8'hFF, 8'hF1);

    repeat (2) @(negedge clk);
    cmp_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
